pipe_ctrl: RTL

- Central pipeline controller for the 5-stage RV32 core.
- Merges hazard and redirect requests from id (load-use stall), exe (multi-cycle busy, taken branch/jump, trap) and mem (outstanding store).
- Produces per-stage stall and flush vectors plus the PC redirect.
- Sequences trap entry through a small FSM that drains mem, then writes mepc/mcause to the CSR file and vectors to mtvec.

---
 rtl/pipe_ctrl_if.sv | 42 ++++
 rtl/pipe_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Purpose : bundle of hazard/redirect requests into pipe_ctrl and the stall/flush/redirect/CSR results out of it.
// Latency : none, plain wires.
// Backpr. : none; the stall_o/flush_o vectors returned to the core are the backpressure.
// Ports   : master = pipe_ctrl side (requests in, controls out); slave = core/bench side (mirror).
interface pipe_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // requests from the pipeline
  logic                  id_stallreq_i;
  logic                  exe_stallreq_i;
  logic                  exe_jump_i;
  logic [ADDR_WIDTH-1:0] exe_jump_addr_i;
  logic                  trap_req_i;
  logic [ADDR_WIDTH-1:0] trap_pc_i;
  logic [DATA_WIDTH-1:0] trap_cause_i;
  logic [DATA_WIDTH-1:0] mtvec_i;
  logic                  mem_busy_i;
  // controls back to the pipeline and the CSR file
  logic [4:0]            stall_o;
  logic [2:0]            flush_o;
  logic                  redirect_o;
  logic [ADDR_WIDTH-1:0] redirect_addr_o;
  logic                  csr_trap_we_o;
  logic [ADDR_WIDTH-1:0] csr_mepc_o;
  logic [DATA_WIDTH-1:0] csr_mcause_o;
  logic                  busy_o;

  modport master (
    input  id_stallreq_i, exe_stallreq_i, exe_jump_i, exe_jump_addr_i,
           trap_req_i, trap_pc_i, trap_cause_i, mtvec_i, mem_busy_i,
    output stall_o, flush_o, redirect_o, redirect_addr_o,
           csr_trap_we_o, csr_mepc_o, csr_mcause_o, busy_o
  );

  modport slave (
    output id_stallreq_i, exe_stallreq_i, exe_jump_i, exe_jump_addr_i,
           trap_req_i, trap_pc_i, trap_cause_i, mtvec_i, mem_busy_i,
    input  stall_o, flush_o, redirect_o, redirect_addr_o,
           csr_trap_we_o, csr_mepc_o, csr_mcause_o, busy_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Purpose : RV32 5-stage pipeline controller: merges id/exe/mem hazards into stall/flush vectors and PC redirect,
//           and sequences trap entry (IDLE -> DRAIN -> COMMIT) with a one-cycle mepc/mcause write.
// Latency : hazard outputs are combinational; trap redirect at N+2 after trap_req_i, +1 per cycle of mem_busy_i in DRAIN.
// Backpr. : stall_o holds stages; mem_busy_i holds the FSM in DRAIN until mem has drained.
// Ports   : clk_i, rst_i (synchronous, active-high; forces all outputs to 0 while asserted); bus = pipe_ctrl_if.master.
// Option  : define PIPE_CTRL_VECTORED_TRAP_EN for vectored interrupt targets when mtvec_i[1:0]==2'b01.
module pipe_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pipe_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] trap_pc_q, trap_pc_d;
  logic [DATA_WIDTH-1:0] trap_cause_q, trap_cause_d;
  logic [ADDR_WIDTH-1:0] trap_target;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      trap_pc_q    <= '0;
      trap_cause_q <= '0;
    end else begin
      state_q      <= state_d;
      trap_pc_q    <= trap_pc_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  // mtvec_i is read live in COMMIT so a CSR write that lands during DRAIN is honoured.
  always_comb begin
    trap_target = ADDR_WIDTH'({bus.mtvec_i[DATA_WIDTH-1:2], 2'b00});
`ifdef PIPE_CTRL_VECTORED_TRAP_EN
    if (bus.mtvec_i[1:0] == 2'b01 && trap_cause_q[DATA_WIDTH-1]) begin
      trap_target = trap_target + (ADDR_WIDTH'(trap_cause_q[DATA_WIDTH-2:0]) << 2);
    end
`endif
  end

  always_comb begin
    state_d             = state_q;
    trap_pc_d           = trap_pc_q;
    trap_cause_d        = trap_cause_q;
    bus.stall_o         = 5'b00000;
    bus.flush_o         = 3'b000;
    bus.redirect_o      = 1'b0;
    bus.redirect_addr_o = '0;
    bus.csr_trap_we_o   = 1'b0;
    bus.csr_mepc_o      = trap_pc_q;
    bus.csr_mcause_o    = trap_cause_q;
    bus.busy_o          = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.trap_req_i) begin
          // Hold younger stages, bubble exe_mem so the trapping op never retires, let mem_wb drain.
          state_d      = DRAIN;
          trap_pc_d    = bus.trap_pc_i;
          trap_cause_d = bus.trap_cause_i;
          bus.stall_o  = 5'b00111;
          bus.flush_o  = 3'b100;
        end else if (bus.exe_stallreq_i) begin
          // A concurrent jump waits: exe keeps presenting it until its busy drops.
          bus.stall_o = 5'b00111;
          bus.flush_o = 3'b100;
        end else if (bus.exe_jump_i) begin
          // Any id load-use stall is moot because id is flushed here.
          bus.flush_o         = 3'b011;
          bus.redirect_o      = 1'b1;
          bus.redirect_addr_o = bus.exe_jump_addr_i;
        end else if (bus.id_stallreq_i) begin
          bus.stall_o = 5'b00011;
          bus.flush_o = 3'b010;
        end
      end
      DRAIN: begin
        bus.stall_o = 5'b00111;
        bus.flush_o = 3'b100;
        if (!bus.mem_busy_i) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d             = IDLE;
        bus.flush_o         = 3'b111;
        bus.redirect_o      = 1'b1;
        bus.redirect_addr_o = trap_target;
        bus.csr_trap_we_o   = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst_i) begin
      bus.stall_o         = 5'b00000;
      bus.flush_o         = 3'b000;
      bus.redirect_o      = 1'b0;
      bus.redirect_addr_o = '0;
      bus.csr_trap_we_o   = 1'b0;
      bus.csr_mepc_o      = '0;
      bus.csr_mcause_o    = '0;
      bus.busy_o          = 1'b0;
    end
  end

endmodule
